// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared state enum, LFSR taps and pattern next-value function for the SDRAM write path
package sdram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } wr_state_t;

  // Fibonacci taps, shift-left form: feedback is the parity of (pat & taps) into bit 0
  localparam logic [31:0] LFSR_TAPS_8  = 32'h0000_00B8;
  localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_D008;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    case (width)
      8:       return LFSR_TAPS_8;
      16:      return LFSR_TAPS_16;
      32:      return LFSR_TAPS_32;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] pat_next(input logic [31:0] pat, input logic [31:0] pat_max,
                                           input logic lfsr_mode, input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    if (lfsr_mode)
      return ((pat << 1) | {31'd0, ^(pat & lfsr_taps(width))}) & mask;
    return (pat == pat_max) ? 32'd0 : ((pat + 32'd1) & mask);
  endfunction

endpackage

// File: rtl/sdram_wr_src_if.sv
// rtl/sdram_wr_src_if.sv - producer side of the SDRAM write-FIFO port
interface sdram_wr_src_if #(parameter int DATA_W = 16);
  logic              wfifo_wr_en;
  logic [DATA_W-1:0] wfifo_wr_data;
  logic              wfifo_afull;

  modport master (output wfifo_wr_en, output wfifo_wr_data, input wfifo_afull);
  modport slave  (input wfifo_wr_en, input wfifo_wr_data, output wfifo_afull);
endinterface

// File: rtl/sdram_pat_gen.sv
// rtl/sdram_pat_gen.sv - pattern register with advance enable; SDRAM_WR_SRC_LFSR_EN selects LFSR instead of ramp
module sdram_pat_gen
  import sdram_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int PAT_MAX = 255
) (
  input  logic              wfifo_wclk,
  input  logic              s_rst_n,
  input  logic              adv,
  output logic [DATA_W-1:0] pat
);

`ifdef SDRAM_WR_SRC_LFSR_EN
  localparam logic              LFSR_MODE = 1'b1;
  localparam logic [DATA_W-1:0] SEED      = DATA_W'(1);
`else
  localparam logic              LFSR_MODE = 1'b0;
  localparam logic [DATA_W-1:0] SEED      = '0;
`endif

  logic [31:0] nxt;

  assign nxt = pat_next(32'(pat), 32'(PAT_MAX), LFSR_MODE, DATA_W);

  always_ff @(posedge wfifo_wclk or negedge s_rst_n) begin
    if (!s_rst_n)
      pat <= SEED;
    else if (adv)
      pat <= DATA_W'(nxt);
  end

endmodule

// File: rtl/sdram_wr_src.sv
// rtl/sdram_wr_src.sv - burst write-data source feeding the SDRAM write FIFO, throttled by almost-full
module sdram_wr_src
  import sdram_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int BURST_LEN  = 256,
  parameter int NUM_BURSTS = 4,
  parameter int GAP_CYC    = 8,
  parameter int PAT_MAX    = 255
) (
  input  logic                 wfifo_wclk,
  input  logic                 s_rst_n,
  input  logic                 start,
  sdram_wr_src_if.master       wfifo,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          word_cnt
);

  localparam int BW = (BURST_LEN  < 2) ? 1 : $clog2(BURST_LEN);
  localparam int NW = (NUM_BURSTS < 2) ? 1 : $clog2(NUM_BURSTS);
  localparam int GW = (GAP_CYC    < 2) ? 1 : $clog2(GAP_CYC);

  localparam logic [BW-1:0] BEAT_LAST  = BW'(BURST_LEN - 1);
  localparam logic [NW-1:0] BURST_LAST = NW'(NUM_BURSTS - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  wr_state_t         state;
  logic [BW-1:0]     beat_cnt;
  logic [NW-1:0]     burst_cnt;
  logic [GW-1:0]     gap_cnt;
  logic [DATA_W-1:0] pat;
  logic              adv;

  // the pattern only moves on an accepted write, so throttling never skips a value
  assign adv = (state == BURST) && !wfifo.wfifo_afull;

  sdram_pat_gen #(.DATA_W(DATA_W), .PAT_MAX(PAT_MAX)) u_pat_gen (
    .wfifo_wclk (wfifo_wclk),
    .s_rst_n    (s_rst_n),
    .adv        (adv),
    .pat        (pat)
  );

  always_ff @(posedge wfifo_wclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state               <= IDLE;
      beat_cnt            <= '0;
      burst_cnt           <= '0;
      gap_cnt             <= '0;
      wfifo.wfifo_wr_en   <= 1'b0;
      wfifo.wfifo_wr_data <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      word_cnt            <= '0;
    end else begin
      wfifo.wfifo_wr_en <= 1'b0;
      done              <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= BURST;
            beat_cnt  <= '0;
            burst_cnt <= '0;
            busy      <= 1'b1;
          end
        end
        BURST: begin
          if (!wfifo.wfifo_afull) begin
            wfifo.wfifo_wr_en   <= 1'b1;
            wfifo.wfifo_wr_data <= pat;
            if (word_cnt != 32'hFFFF_FFFF)
              word_cnt <= word_cnt + 32'd1;
            if (beat_cnt == BEAT_LAST) begin
              beat_cnt  <= '0;
              burst_cnt <= burst_cnt + NW'(1);
              if (burst_cnt == BURST_LAST) begin
                state <= DONE;
              end else if (GAP_CYC != 0) begin
                state   <= GAP;
                gap_cnt <= '0;
              end
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST)
            state <= BURST;
          else
            gap_cnt <= gap_cnt + GW'(1);
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sdram_wr_src.md
# sdram_wr_src

Write-data source for the SDRAM write path, running in the `wfifo_wclk` domain. It produces a configured number of fixed-length bursts of pattern data on `wfifo_wr_en` / `wfifo_wr_data`, which is the producer end of the write-FIFO interface of `sdram_top`. It throttles on the FIFO almost-full flag and reports completion. It is the synthesizable replacement for the bench-side ramp generator, so hardware bring-up and simulation use the same stimulus.

## Interface

Parameters:
- `DATA_W`, default 16: width of `wfifo_wr_data`.
- `BURST_LEN`, default 256: words per burst, must be ≥1.
- `NUM_BURSTS`, default 4: bursts per run, must be ≥1.
- `GAP_CYC`, default 8: idle cycles between bursts; 0 is legal.
- `PAT_MAX`, default 255: ramp wraps from this value back to 0; must be < 2^DATA_W.

Ports (clock, then reset, then the rest):
- `wfifo_wclk` in 1: clock.
- `s_rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle run request, sampled only in IDLE.
- `wfifo_afull` in 1: FIFO almost-full. The FIFO must guarantee at least 1 free word when it asserts this flag.
- `wfifo_wr_en` out 1: write strobe, registered.
- `wfifo_wr_data` out DATA_W: write data, registered, valid when `wfifo_wr_en`=1.
- `busy` out 1: high from the cycle after `start` is accepted until the DONE state is left.
- `done` out 1: single-cycle pulse at the end of a run.
- `word_cnt` out 32: words written since reset, saturating at 2^32−1.

## Operation

- States: IDLE, BURST, GAP, DONE.
- IDLE: if `start`=1, go to BURST, clear `beat_cnt` and `burst_cnt`. The pattern register is not cleared, so consecutive runs continue the pattern.
- BURST: each cycle with `wfifo_afull`=0, perform one accepted write:
  - register `wfifo_wr_en`<=1 and `wfifo_wr_data`<=pattern;
  - advance the pattern and increment `beat_cnt` and `word_cnt`.
- BURST with `wfifo_afull`=1: `wfifo_wr_en`<=0 and all counters hold.
- End of a burst is the write with `beat_cnt`=BURST_LEN−1. On that write, clear `beat_cnt` and increment `burst_cnt`, then:
  - if `burst_cnt`=NUM_BURSTS−1, go to DONE;
  - else if GAP_CYC=0, stay in BURST;
  - else go to GAP.
- GAP: count GAP_CYC cycles with `wfifo_wr_en`=0, then go to BURST.
- DONE: `done`<=1 for one cycle, then go to IDLE.
- Ramp pattern: next = (pattern==PAT_MAX) ? 0 : pattern+1. Reset value is 0.
- `start` outside IDLE is ignored. No queuing.
- `wfifo_wr_data` holds its last value when `wfifo_wr_en`=0.
- `s_rst_n` low at any time forces IDLE immediately. The run in progress is abandoned, with no flush.

## Timing

- Reset values: `wfifo_wr_en`=0, `wfifo_wr_data`=0, `busy`=0, `done`=0, `word_cnt`=0, pattern=0, state IDLE.
- Start latency: `start` high at edge N → state BURST at N. The first `wfifo_wr_en` is visible after edge N+1 if `wfifo_afull`=0 at N+1.
- Throughput is 1 word/cycle while `wfifo_afull`=0.
- Throttle: `wfifo_afull` sampled high at edge M → `wfifo_wr_en`=0 after M. At most one write lands after the FIFO raises the flag, which is covered by the 1-word headroom.
- Burst spacing: last write of burst k to first write of burst k+1 is GAP_CYC+1 cycles apart, with no throttling.
- `done` rises one cycle after the final write of the run. `busy` falls together with `done`.

## Configuration

- `SDRAM_WR_SRC_LFSR_EN` defined: the pattern is a DATA_W-bit maximal-length Fibonacci LFSR with seed 1. Each accepted write shifts it once. PAT_MAX is ignored. The LFSR never reaches the value 0.
- `SDRAM_WR_SRC_LFSR_EN` undefined: the ramp pattern with PAT_MAX wrap is used.

## Structure

- Shared package `sdram_pkg`:
  - state enum {IDLE, BURST, GAP, DONE};
  - LFSR tap constants for DATA_W = 8, 16 and 32;
  - the function `pat_next()`.
- One sub-module, `sdram_pat_gen`. It holds the pattern register and next-value logic (ramp or LFSR) with an advance-enable input, so a future read-back checker can reuse it.

## Test plan

1. Defaults, `wfifo_afull`=0, one `start` pulse → 1024 writes in 4 runs of 256 contiguous cycles, each gap 8 cycles wide. Data is 0..255 repeated 4 times. One `done` pulse. `word_cnt`=1024.
2. PAT_MAX=9, BURST_LEN=25, NUM_BURSTS=1 → data 0..9,0..9,0..4. A second `start` then begins at 5.
3. Toggle `wfifo_afull` high for 3 cycles mid-burst → exactly one further write after the rise, then 3 cycles with no writes, then the sequence resumes with no skipped or repeated value.
4. GAP_CYC=0, NUM_BURSTS=2, BURST_LEN=4 → 8 back-to-back writes, data 0..7. `done` one cycle after the 8th write.
5. `start` pulsed while `busy`=1; `s_rst_n` pulsed low mid-burst → the extra start has no effect. On reset, all outputs return to their reset values immediately, and a following `start` restarts the data at 0.
6. `SDRAM_WR_SRC_LFSR_EN` defined, DATA_W=16 → first data 1. Sequence matches the package LFSR model over 65535 writes with no value 0.
